// File: rtl/countdown_sched.sv
// Round-robin owner of the single shared countdown timer: arbitrates requesters,
// loads and starts the timer, and returns a done pulse (plus err on an arm timeout).
module countdown_sched #(
    parameter int NREQ   = 4,
    parameter int CNT_W  = 7,
    parameter int ARM_TO = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] preset,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    output logic                  tmr_start,
    output logic [CNT_W-1:0]      tmr_preset,
    input  logic [CNT_W-1:0]      tmr_count,
    input  logic                  tmr_active
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(ARM_TO + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    arm_cnt_q, arm_cnt_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] preset_q, preset_d;

    logic             found_s;
    logic [PW-1:0]    win_s;
    logic [CNT_W-1:0] win_preset_s;

    // First set request searching upward from rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req[idx]) begin
                found_s = 1'b1;
                win_s   = PW'(idx);
            end else begin
                found_s = found_s;
            end
        end
        win_preset_s = preset[win_s*CNT_W +: CNT_W];
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        arm_cnt_d = arm_cnt_q;
        grant_d   = grant_q;
        done_d    = {NREQ{1'b0}};
        err_d     = 1'b0;
        busy_d    = busy_q;
        start_d   = 1'b0;
        preset_d  = preset_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d        = S_LOAD;
                    owner_d        = win_s;
                    preset_d       = win_preset_s;
                    grant_d        = {NREQ{1'b0}};
                    grant_d[win_s] = 1'b1;
                    busy_d         = 1'b1;
                    // Start is registered, so it is decided here to land in LOAD.
                    start_d        = (win_preset_s != {CNT_W{1'b0}});
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (preset_q == {CNT_W{1'b0}}) begin
                    state_d         = S_DONE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    state_d   = S_ARM;
                    arm_cnt_d = {AW{1'b0}};
                end
            end
            S_ARM: begin
                if (tmr_active) begin
                    state_d = S_RUN;
                end else if ((arm_cnt_q + AW'(2)) == AW'(ARM_TO)) begin
                    // The LOAD cycle plus ARM cycles so far have used up ARM_TO.
                    state_d         = S_DONE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            S_RUN: begin
                if (!tmr_active && (tmr_count == {CNT_W{1'b0}})) begin
                    state_d         = S_DONE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                grant_d  = {NREQ{1'b0}};
                busy_d   = 1'b0;
                rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? {PW{1'b0}} : owner_q + PW'(1);
            end
            default: begin
                state_d = S_IDLE;
                grant_d = {NREQ{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= {PW{1'b0}};
            rr_ptr_q  <= {PW{1'b0}};
            arm_cnt_q <= {AW{1'b0}};
            grant_q   <= {NREQ{1'b0}};
            done_q    <= {NREQ{1'b0}};
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            preset_q  <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            arm_cnt_q <= arm_cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            preset_q  <= preset_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign tmr_start  = start_q;
    assign tmr_preset = preset_q;

endmodule

// File: tb/tb_countdown_sched.sv
// Directed bench for countdown_sched with a reference-style countdown stub.
module tb_countdown_sched;

    localparam int NREQ  = 4;
    localparam int CNT_W = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] preset;
    logic [NREQ-1:0]       grant, done;
    logic                  err, busy, tmr_start;
    logic [CNT_W-1:0]      tmr_preset, tmr_count;
    logic                  tmr_active;

    logic [CNT_W-1:0]      t_cnt;
    logic                  t_act;
    logic                  stub_dead;

    int n_cmp = 0;
    int n_err = 0;
    int cyc, bad, saw_done;
    logic [NREQ-1:0] exp_g;

    countdown_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .ARM_TO(4)) dut (
        .clk(clk), .rst(rst), .req(req), .preset(preset),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .tmr_start(tmr_start), .tmr_preset(tmr_preset),
        .tmr_count(tmr_count), .tmr_active(tmr_active)
    );

    always #5 clk = ~clk;

    // Countdown stub: load on start, count to zero, drop active one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_cnt <= '0;
            t_act <= 1'b0;
        end else if (tmr_start) begin
            t_cnt <= tmr_preset;
            t_act <= 1'b1;
        end else if (t_act) begin
            if (t_cnt == '0) t_act <= 1'b0;
            else             t_cnt <= t_cnt - 7'd1;
        end
    end
    assign tmr_count  = t_cnt;
    assign tmr_active = t_act & ~stub_dead;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_p(input int i, input logic [CNT_W-1:0] v);
        preset[i*CNT_W +: CNT_W] = v;
    endtask

    task automatic wait_grant(output int c);
        c = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            c++;
            if (grant !== 4'b0000) break;
        end
    endtask

    task automatic wait_done(input logic [NREQ-1:0] g, output int c, output int b);
        c = 0;
        b = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            c++;
            if (grant !== g) b++;
            if (tmr_start !== 1'b0) b++;
            if (done !== 4'b0000) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; preset = '0; stub_dead = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(4'b0000));
        chk("rst_done", 32'(done), 32'(4'b0000));
        chk("rst_err", 32'(err), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_start", 32'(tmr_start), 32'(1'b0));
        chk("rst_preset", 32'(tmr_preset), 32'(7'd0));
        rst = 1'b0;

        // Single request, preset 5: done 8 cycles after start.
        @(negedge clk);
        set_p(0, 7'd5); req = 4'b0001;
        wait_grant(cyc);
        chk("t1_lat", 32'(cyc), 32'(1));
        chk("t1_grant", 32'(grant), 32'(4'b0001));
        chk("t1_busy", 32'(busy), 32'(1'b1));
        chk("t1_start", 32'(tmr_start), 32'(1'b1));
        chk("t1_preset", 32'(tmr_preset), 32'(7'd5));
        wait_done(4'b0001, cyc, bad);
        chk("t1_done_lat", 32'(cyc), 32'(8));
        chk("t1_done", 32'(done), 32'(4'b0001));
        chk("t1_err", 32'(err), 32'(1'b0));
        chk("t1_held", 32'(bad), 32'(0));
        req = 4'b0000;
        @(negedge clk);
        chk("t1_idle_grant", 32'(grant), 32'(4'b0000));
        chk("t1_idle_done", 32'(done), 32'(4'b0000));
        chk("t1_idle_busy", 32'(busy), 32'(1'b0));

        // Two simultaneous requests: 1 (preset 3) then 2 (preset 10).
        set_p(1, 7'd3); set_p(2, 7'd10); req = 4'b0110;
        wait_grant(cyc);
        chk("t2_lat", 32'(cyc), 32'(1));
        chk("t2_grant1", 32'(grant), 32'(4'b0010));
        chk("t2_preset1", 32'(tmr_preset), 32'(7'd3));
        wait_done(4'b0010, cyc, bad);
        chk("t2_done1_lat", 32'(cyc), 32'(6));
        chk("t2_done1", 32'(done), 32'(4'b0010));
        chk("t2_held1", 32'(bad), 32'(0));
        req = 4'b0100;
        wait_grant(cyc);
        chk("t2_gap", 32'(cyc), 32'(2));
        chk("t2_grant2", 32'(grant), 32'(4'b0100));
        chk("t2_preset2", 32'(tmr_preset), 32'(7'd10));
        chk("t2_start2", 32'(tmr_start), 32'(1'b1));
        wait_done(4'b0100, cyc, bad);
        chk("t2_done2_lat", 32'(cyc), 32'(13));
        chk("t2_done2", 32'(done), 32'(4'b0100));
        chk("t2_held2", 32'(bad), 32'(0));
        req = 4'b0000;

        // Reset pulse so fairness starts from rr_ptr = 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'(1'b0));
        rst = 1'b0;

        // Fairness: all requests held, presets 2.
        for (int i = 0; i < NREQ; i++) set_p(i, 7'd2);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(cyc);
            chk("fair_lat", 32'(cyc), (i == 0) ? 32'(1) : 32'(2));
            exp_g = 4'b0001 << (i % 4);
            chk("fair_grant", 32'(grant), 32'(exp_g));
            wait_done(exp_g, cyc, bad);
            chk("fair_done_lat", 32'(cyc), 32'(5));
            chk("fair_done", 32'(done), 32'(exp_g));
            chk("fair_held", 32'(bad), 32'(0));
            if (i == 4) req = 4'b0000;
        end

        // Zero preset on requester 3.
        @(negedge clk);
        set_p(3, 7'd0); req = 4'b1000;
        wait_grant(cyc);
        chk("t4_lat", 32'(cyc), 32'(1));
        chk("t4_grant", 32'(grant), 32'(4'b1000));
        chk("t4_nostart", 32'(tmr_start), 32'(1'b0));
        chk("t4_busy", 32'(busy), 32'(1'b1));
        wait_done(4'b1000, cyc, bad);
        chk("t4_done_lat", 32'(cyc), 32'(1));
        chk("t4_done", 32'(done), 32'(4'b1000));
        chk("t4_err", 32'(err), 32'(1'b0));
        chk("t4_held", 32'(bad), 32'(0));
        req = 4'b0000;
        @(negedge clk);
        chk("t4_grant_clr", 32'(grant), 32'(4'b0000));
        chk("t4_done_clr", 32'(done), 32'(4'b0000));

        // ARM timeout: timer never reports active.
        stub_dead = 1'b1;
        set_p(1, 7'd6); req = 4'b0010;
        wait_grant(cyc);
        chk("t5_grant", 32'(grant), 32'(4'b0010));
        chk("t5_start", 32'(tmr_start), 32'(1'b1));
        wait_done(4'b0010, cyc, bad);
        chk("t5_done_lat", 32'(cyc), 32'(4));
        chk("t5_done", 32'(done), 32'(4'b0010));
        chk("t5_err", 32'(err), 32'(1'b1));
        req = 4'b0000; stub_dead = 1'b0;
        @(negedge clk);
        chk("t5_err_clr", 32'(err), 32'(1'b0));
        chk("t5_done_clr", 32'(done), 32'(4'b0000));
        set_p(2, 7'd2); req = 4'b0100;
        wait_grant(cyc);
        chk("t5_next_grant", 32'(grant), 32'(4'b0100));
        wait_done(4'b0100, cyc, bad);
        chk("t5_next_lat", 32'(cyc), 32'(5));
        chk("t5_next_err", 32'(err), 32'(1'b0));
        req = 4'b0000;

        // Reset during RUN; rr_ptr would otherwise favour requester 3.
        @(negedge clk);
        set_p(0, 7'd10); set_p(3, 7'd4); req = 4'b0001;
        wait_grant(cyc);
        chk("t6_grant", 32'(grant), 32'(4'b0001));
        req = 4'b1001;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_grant_rst", 32'(grant), 32'(4'b0000));
        chk("t6_done_rst", 32'(done), 32'(4'b0000));
        chk("t6_err_rst", 32'(err), 32'(1'b0));
        chk("t6_busy_rst", 32'(busy), 32'(1'b0));
        chk("t6_start_rst", 32'(tmr_start), 32'(1'b0));
        chk("t6_preset_rst", 32'(tmr_preset), 32'(7'd0));
        saw_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 4'b0000) saw_done++;
        end
        rst = 1'b0;
        wait_grant(cyc);
        chk("t6_no_done", 32'(saw_done), 32'(0));
        chk("t6_regrant_lat", 32'(cyc), 32'(1));
        chk("t6_regrant", 32'(grant), 32'(4'b0001));
        chk("t6_preset", 32'(tmr_preset), 32'(7'd10));
        wait_done(4'b0001, cyc, bad);
        chk("t6_done_lat", 32'(cyc), 32'(13));
        chk("t6_done", 32'(done), 32'(4'b0001));
        req = 4'b0000;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
